// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: EX-stage issue for the ALU. Decodes the ID instruction
// into a 3-bit ALU code, selects operands and holds them in the ID/EX
// register. A mul stays in EX for MUL_CYCLES cycles in total before it is
// presented as valid.
//
// Handshake (both sides): a transfer happens on a rising edge where valid
// and ready are both high. The sender keeps its payload stable while valid
// is high and ready is low. On the ID side a flush_i cycle also raises
// id_ready_o, and ID treats its offer as consumed (the op is dropped).
module alu_issue_ctrl #(
  parameter int MUL_CYCLES = 3
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        flush_i,
  input  logic        id_valid_i,
  output logic        id_ready_o,
  input  logic [6:0]  opcode_i,
  input  logic [2:0]  funct3_i,
  input  logic [6:0]  funct7_i,
  input  logic [31:0] rs1_data_i,
  input  logic [31:0] rs2_data_i,
  input  logic [11:0] imm_i,
  input  logic [4:0]  rd_i,
  output logic        ex_valid_o,
  input  logic        ex_ready_i,
  output logic [2:0]  alu_ctrl_o,
  output logic [31:0] op1_o,
  output logic [31:0] op2_o,
  output logic [4:0]  rd_o,
  output logic        regwrite_o,
  output logic        illegal_o,
  output logic        busy_o,
  output logic [1:0]  state_dbg_o
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_MUL   = 2'd1,
    S_VALID = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OP2_RS2   = 2'd0,
    OP2_SIMM  = 2'd1,
    OP2_SHAMT = 2'd2
  } op2_sel_t;

  // Counter only ever holds MUL_CYCLES-1 down to 1.
  localparam int CW = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) + 1 : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(MUL_CYCLES - 1);
  localparam bit MUL_STALLS = (MUL_CYCLES > 1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    alu_ctrl_q, alu_ctrl_d;
  logic [31:0]   op1_q, op1_d;
  logic [31:0]   op2_q, op2_d;
  logic [4:0]    rd_q, rd_d;
  logic          regwrite_q, regwrite_d;
  logic          illegal_q, illegal_d;

  logic [2:0]    dec_code;
  logic          dec_rw;
  logic          dec_ill;
  logic          dec_mul;
  op2_sel_t      dec_sel;
  logic [31:0]   dec_op2;
  logic          accept;

  // Instruction decode: anything not matched falls through as illegal.
  always_comb begin
    dec_code = 3'b010;
    dec_rw   = 1'b0;
    dec_ill  = 1'b1;
    dec_mul  = 1'b0;
    dec_sel  = OP2_RS2;
    case (opcode_i)
      7'b0110011: begin
        if (funct7_i == 7'b0000000) begin
          case (funct3_i)
            3'b111:  begin dec_code = 3'b000; dec_rw = 1'b1; dec_ill = 1'b0; end
            3'b100:  begin dec_code = 3'b111; dec_rw = 1'b1; dec_ill = 1'b0; end
            3'b001:  begin dec_code = 3'b011; dec_rw = 1'b1; dec_ill = 1'b0; end
            3'b000:  begin dec_code = 3'b010; dec_rw = 1'b1; dec_ill = 1'b0; end
            default: ;
          endcase
        end else if (funct7_i == 7'b0100000 && funct3_i == 3'b000) begin
          dec_code = 3'b110; dec_rw = 1'b1; dec_ill = 1'b0;
        end else if (funct7_i == 7'b0000001 && funct3_i == 3'b000) begin
          dec_code = 3'b100; dec_rw = 1'b1; dec_ill = 1'b0; dec_mul = 1'b1;
        end
      end
      7'b0010011: begin
        if (funct3_i == 3'b000) begin
          dec_code = 3'b010; dec_rw = 1'b1; dec_ill = 1'b0; dec_sel = OP2_SIMM;
        end else if (funct3_i == 3'b101 && funct7_i == 7'b0100000) begin
          dec_code = 3'b001; dec_rw = 1'b1; dec_ill = 1'b0; dec_sel = OP2_SHAMT;
        end
      end
      7'b0000011: begin
        if (funct3_i == 3'b010) begin
          dec_code = 3'b010; dec_rw = 1'b1; dec_ill = 1'b0; dec_sel = OP2_SIMM;
        end
      end
      7'b0100011: begin
        if (funct3_i == 3'b010) begin
          dec_code = 3'b010; dec_ill = 1'b0; dec_sel = OP2_SIMM;
        end
      end
      7'b1100011: begin
        if (funct3_i == 3'b000) begin
          dec_code = 3'b110; dec_ill = 1'b0;
        end
      end
      default: ;
    endcase
    case (dec_sel)
      OP2_SIMM:  dec_op2 = {{20{imm_i[11]}}, imm_i};
      OP2_SHAMT: dec_op2 = {27'b0, imm_i[4:0]};
      default:   dec_op2 = rs2_data_i;
    endcase
  end

  // ID-side ready and the accept strobe; a flush swallows the ID offer.
  always_comb begin
    if (flush_i) begin
      id_ready_o = 1'b1;
    end else begin
      case (state_q)
        S_EMPTY: id_ready_o = 1'b1;
        S_VALID: id_ready_o = ex_ready_i;
        default: id_ready_o = 1'b0;
      endcase
    end
    accept = id_valid_i && id_ready_o && !flush_i;
  end

  // Next-state and ID/EX payload; payload moves only on accept or flush.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    alu_ctrl_d = alu_ctrl_q;
    op1_d      = op1_q;
    op2_d      = op2_q;
    rd_d       = rd_q;
    regwrite_d = regwrite_q;
    illegal_d  = illegal_q;
    if (flush_i) begin
      state_d    = S_EMPTY;
      cnt_d      = '0;
      alu_ctrl_d = '0;
      op1_d      = '0;
      op2_d      = '0;
      rd_d       = '0;
      regwrite_d = 1'b0;
      illegal_d  = 1'b0;
    end else begin
      case (state_q)
        S_MUL: begin
          if (cnt_q <= CW'(1)) begin
            state_d = S_VALID;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
        S_VALID: begin
          if (ex_ready_i && !id_valid_i) state_d = S_EMPTY;
        end
        default: ;
      endcase
      if (accept) begin
        alu_ctrl_d = dec_code;
        op1_d      = rs1_data_i;
        op2_d      = dec_op2;
        rd_d       = rd_i;
        regwrite_d = dec_rw;
        illegal_d  = dec_ill;
        if (dec_mul && MUL_STALLS) begin
          state_d = S_MUL;
          cnt_d   = CNT_LOAD;
        end else begin
          state_d = S_VALID;
          cnt_d   = '0;
        end
      end
    end
  end

  // State, counter and ID/EX register; async reset aborts any mul.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= S_EMPTY;
      cnt_q      <= '0;
      alu_ctrl_q <= '0;
      op1_q      <= '0;
      op2_q      <= '0;
      rd_q       <= '0;
      regwrite_q <= 1'b0;
      illegal_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      alu_ctrl_q <= alu_ctrl_d;
      op1_q      <= op1_d;
      op2_q      <= op2_d;
      rd_q       <= rd_d;
      regwrite_q <= regwrite_d;
      illegal_q  <= illegal_d;
    end
  end

  assign ex_valid_o  = (state_q == S_VALID);
  assign busy_o      = (state_q == S_MUL);
  assign state_dbg_o = state_q;
  assign alu_ctrl_o  = alu_ctrl_q;
  assign op1_o       = op1_q;
  assign op2_o       = op2_q;
  assign rd_o        = rd_q;
  assign regwrite_o  = regwrite_q;
  assign illegal_o   = illegal_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: directed scenarios followed by randomized traffic.
// Expected results come from a table of legal encodings and an in-order
// queue of accepted operations.
module tb_alu_issue_ctrl;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_i = 1'b0;
  logic        flush_i = 1'b0;
  logic        id_valid_i = 1'b0;
  logic        id_ready_o;
  logic [6:0]  opcode_i = '0;
  logic [2:0]  funct3_i = '0;
  logic [6:0]  funct7_i = '0;
  logic [31:0] rs1_data_i = '0;
  logic [31:0] rs2_data_i = '0;
  logic [11:0] imm_i = '0;
  logic [4:0]  rd_i = '0;
  logic        ex_valid_o;
  logic        ex_ready_i = 1'b0;
  logic [2:0]  alu_ctrl_o;
  logic [31:0] op1_o;
  logic [31:0] op2_o;
  logic [4:0]  rd_o;
  logic        regwrite_o;
  logic        illegal_o;
  logic        busy_o;
  logic [1:0]  state_dbg_o;

  alu_issue_ctrl #(.MUL_CYCLES(3)) dut (
    .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i),
    .id_valid_i(id_valid_i), .id_ready_o(id_ready_o),
    .opcode_i(opcode_i), .funct3_i(funct3_i), .funct7_i(funct7_i),
    .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i), .imm_i(imm_i), .rd_i(rd_i),
    .ex_valid_o(ex_valid_o), .ex_ready_i(ex_ready_i),
    .alu_ctrl_o(alu_ctrl_o), .op1_o(op1_o), .op2_o(op2_o), .rd_o(rd_o),
    .regwrite_o(regwrite_o), .illegal_o(illegal_o), .busy_o(busy_o),
    .state_dbg_o(state_dbg_o)
  );

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  typedef struct {
    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    bit         use_f7;
    logic [2:0] code;
    bit         rw;
    int         sel;   // 0: rs2, 1: sign-extended imm, 2: shamt
  } enc_t;

  enc_t enc_tab[11];

  // Packed expectation: {illegal, regwrite, rd, code, op2, op1}
  localparam int W = 74;
  logic [W-1:0] exp_q[$];

  int checks = 0;
  int failures = 0;

  function automatic logic [W-1:0] model(input logic [6:0] opc, input logic [2:0] f3,
                                         input logic [6:0] f7, input logic [31:0] rs1,
                                         input logic [31:0] rs2, input logic [11:0] imm,
                                         input logic [4:0] rd);
    logic [31:0] o2;
    for (int i = 0; i < 11; i++) begin
      if (enc_tab[i].opc == opc && enc_tab[i].f3 == f3 &&
          (!enc_tab[i].use_f7 || enc_tab[i].f7 == f7)) begin
        if (enc_tab[i].sel == 1)      o2 = 32'(signed'(imm));
        else if (enc_tab[i].sel == 2) o2 = 32'(imm[4:0]);
        else                          o2 = rs2;
        return {1'b0, enc_tab[i].rw, rd, enc_tab[i].code, o2, rs1};
      end
    end
    return {1'b1, 1'b0, rd, 3'b010, 32'h0, rs1};
  endfunction

  // ---------------- checker ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [31:0] rs1, input logic [31:0] rs2,
                       input logic [11:0] imm, input logic [4:0] rd);
    opcode_i = opc; funct3_i = f3; funct7_i = f7;
    rs1_data_i = rs1; rs2_data_i = rs2; imm_i = imm; rd_i = rd;
  endtask

  // One clock: scoreboard the handshakes just before the edge, then step.
  task automatic tick();
    logic acc, outf;
    logic [W-1:0] e;
    @(negedge clk);
    acc  = id_valid_i && id_ready_o && !flush_i;
    outf = ex_valid_o && ex_ready_i && !flush_i;
    if (ex_valid_o) chk("sb_pending", 32'(exp_q.size() > 0), 32'd1);
    if (outf && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("sb_illegal", 32'(illegal_o), 32'(e[73]));
      chk("sb_regwrite", 32'(regwrite_o), 32'(e[72]));
      chk("sb_rd", 32'(rd_o), 32'(e[71:67]));
      chk("sb_code", 32'(alu_ctrl_o), 32'(e[66:64]));
      chk("sb_op1", op1_o, e[31:0]);
      if (!e[73]) chk("sb_op2", op2_o, e[63:32]);
    end
    if (flush_i) exp_q.delete();
    else if (acc) exp_q.push_back(model(opcode_i, funct3_i, funct7_i, rs1_data_i,
                                        rs2_data_i, imm_i, rd_i));
    @(posedge clk);
    #1;
  endtask

  localparam logic [6:0] R_OP = 7'b0110011;
  localparam logic [6:0] I_OP = 7'b0010011;

  // ---------------- stimulus ----------------
  initial begin
    int idx;
    logic [6:0] ropc, rf7;
    logic [2:0] rf3;
    enc_tab[0]  = '{7'b0110011, 3'b111, 7'b0000000, 1'b1, 3'b000, 1'b1, 0};
    enc_tab[1]  = '{7'b0110011, 3'b100, 7'b0000000, 1'b1, 3'b111, 1'b1, 0};
    enc_tab[2]  = '{7'b0110011, 3'b001, 7'b0000000, 1'b1, 3'b011, 1'b1, 0};
    enc_tab[3]  = '{7'b0110011, 3'b000, 7'b0000000, 1'b1, 3'b010, 1'b1, 0};
    enc_tab[4]  = '{7'b0110011, 3'b000, 7'b0100000, 1'b1, 3'b110, 1'b1, 0};
    enc_tab[5]  = '{7'b0110011, 3'b000, 7'b0000001, 1'b1, 3'b100, 1'b1, 0};
    enc_tab[6]  = '{7'b0010011, 3'b000, 7'b0000000, 1'b0, 3'b010, 1'b1, 1};
    enc_tab[7]  = '{7'b0010011, 3'b101, 7'b0100000, 1'b1, 3'b001, 1'b1, 2};
    enc_tab[8]  = '{7'b0000011, 3'b010, 7'b0000000, 1'b0, 3'b010, 1'b1, 1};
    enc_tab[9]  = '{7'b0100011, 3'b010, 7'b0000000, 1'b0, 3'b010, 1'b0, 1};
    enc_tab[10] = '{7'b1100011, 3'b000, 7'b0000000, 1'b0, 3'b110, 1'b0, 0};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ex_valid", 32'(ex_valid_o), 0);
    chk("rst_busy", 32'(busy_o), 0);
    chk("rst_code", 32'(alu_ctrl_o), 0);
    chk("rst_op1", op1_o, 0);
    chk("rst_regwrite", 32'(regwrite_o), 0);
    @(negedge clk);
    rst_i = 1'b1;
    #1;
    chk("rst_id_ready", 32'(id_ready_o), 1);
    @(posedge clk);
    #1;

    // 1: add x3 = x1 + x2
    ex_ready_i = 1'b1;
    id_valid_i = 1'b1;
    drive(R_OP, 3'b000, 7'b0000000, 32'd5, 32'd7, 12'h0, 5'd3);
    tick();
    chk("add_valid", 32'(ex_valid_o), 1);
    chk("add_code", 32'(alu_ctrl_o), 32'b010);
    chk("add_op1", op1_o, 32'd5);
    chk("add_op2", op2_o, 32'd7);
    chk("add_rd", 32'(rd_o), 32'd3);
    chk("add_rw", 32'(regwrite_o), 1);

    // 2: addi with negative immediate, then srai
    drive(I_OP, 3'b000, 7'b1111111, 32'd1, 32'd9, 12'hFFF, 5'd4);
    tick();
    chk("addi_op2", op2_o, 32'hFFFF_FFFF);
    chk("addi_code", 32'(alu_ctrl_o), 32'b010);
    drive(I_OP, 3'b101, 7'b0100000, 32'h8000_0000, 32'd9, 12'h403, 5'd6);
    tick();
    chk("srai_op2", op2_o, 32'd3);
    chk("srai_code", 32'(alu_ctrl_o), 32'b001);

    // 3: mul with a queued op behind it
    drive(R_OP, 3'b000, 7'b0000001, 32'd6, 32'd7, 12'h0, 5'd5);
    tick();
    drive(R_OP, 3'b000, 7'b0000000, 32'd1, 32'd2, 12'h0, 5'd9);
    for (int c = 0; c < 2; c++) begin
      chk("mul_busy", 32'(busy_o), 1);
      chk("mul_id_ready", 32'(id_ready_o), 0);
      chk("mul_ex_valid", 32'(ex_valid_o), 0);
      tick();
    end
    chk("mul_done_valid", 32'(ex_valid_o), 1);
    chk("mul_done_code", 32'(alu_ctrl_o), 32'b100);
    chk("mul_done_busy", 32'(busy_o), 0);
    chk("mul_done_id_ready", 32'(id_ready_o), 1);
    tick();
    chk("queued_valid", 32'(ex_valid_o), 1);
    chk("queued_rd", 32'(rd_o), 32'd9);

    // 4: downstream stall while holding an xor
    drive(R_OP, 3'b100, 7'b0000000, 32'hF0F0, 32'h0FF0, 12'h0, 5'd10);
    tick();
    ex_ready_i = 1'b0;
    drive(R_OP, 3'b111, 7'b0000000, 32'd3, 32'd4, 12'h0, 5'd11);
    #1;
    for (int c = 0; c < 4; c++) begin
      chk("stall_id_ready", 32'(id_ready_o), 0);
      chk("stall_valid", 32'(ex_valid_o), 1);
      chk("stall_code", 32'(alu_ctrl_o), 32'b111);
      chk("stall_rd", 32'(rd_o), 32'd10);
      chk("stall_op1", op1_o, 32'hF0F0);
      tick();
    end
    ex_ready_i = 1'b1;
    tick();
    chk("release_code", 32'(alu_ctrl_o), 32'b000);
    chk("release_rd", 32'(rd_o), 32'd11);

    // 5: flush during mul, then an illegal opcode
    drive(R_OP, 3'b000, 7'b0000001, 32'd2, 32'd3, 12'h0, 5'd7);
    tick();
    flush_i = 1'b1;
    drive(R_OP, 3'b000, 7'b0000000, 32'd8, 32'd8, 12'h0, 5'd8);
    #1;
    chk("flush_id_ready", 32'(id_ready_o), 1);
    tick();
    flush_i = 1'b0;
    chk("flush_valid", 32'(ex_valid_o), 0);
    chk("flush_busy", 32'(busy_o), 0);
    chk("flush_code", 32'(alu_ctrl_o), 0);
    chk("flush_op1", op1_o, 0);
    chk("flush_op2", op2_o, 0);
    chk("flush_rd", 32'(rd_o), 0);
    drive(7'b1111111, 3'b000, 7'b0000000, 32'd1, 32'd1, 12'h0, 5'd12);
    tick();
    chk("ill_valid", 32'(ex_valid_o), 1);
    chk("ill_flag", 32'(illegal_o), 1);
    chk("ill_rw", 32'(regwrite_o), 0);
    chk("ill_code", 32'(alu_ctrl_o), 32'b010);

    // 6: asynchronous reset in the middle of a mul
    drive(R_OP, 3'b000, 7'b0000001, 32'd4, 32'd4, 12'h0, 5'd13);
    tick();
    id_valid_i = 1'b0;
    #2 rst_i = 1'b0;
    #1;
    chk("arst_busy", 32'(busy_o), 0);
    chk("arst_valid", 32'(ex_valid_o), 0);
    chk("arst_code", 32'(alu_ctrl_o), 0);
    chk("arst_op1", op1_o, 0);
    chk("arst_rd", 32'(rd_o), 0);
    exp_q.delete();
    #2 rst_i = 1'b1;
    #1;
    chk("arst_rel_id_ready", 32'(id_ready_o), 1);
    chk("arst_rel_busy", 32'(busy_o), 0);
    @(posedge clk);
    #1;
    chk("arst_idle_valid", 32'(ex_valid_o), 0);

    // Randomized traffic against the queue model
    for (int n = 0; n < 400; n++) begin
      idx = $urandom_range(0, 12);
      if (idx < 11) begin
        ropc = enc_tab[idx].opc;
        rf3  = enc_tab[idx].f3;
        rf7  = enc_tab[idx].use_f7 ? enc_tab[idx].f7 : 7'($urandom);
      end else if (idx == 11) begin
        ropc = 7'b1111111; rf3 = 3'($urandom); rf7 = 7'($urandom);
      end else begin
        ropc = 7'($urandom); rf3 = 3'($urandom); rf7 = 7'($urandom);
      end
      drive(ropc, rf3, rf7, $urandom, $urandom, 12'($urandom), 5'($urandom));
      id_valid_i = ($urandom_range(0, 9) < 7);
      ex_ready_i = ($urandom_range(0, 9) < 7);
      flush_i    = ($urandom_range(0, 29) == 0);
      tick();
    end

    // Drain whatever is still in flight
    flush_i = 1'b0;
    id_valid_i = 1'b0;
    ex_ready_i = 1'b1;
    for (int n = 0; n < 20 && exp_q.size() > 0; n++) tick();
    chk("drain_empty", 32'(exp_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
